// File: rtl/alu_exec_unit.sv
// Execution core: single-cycle ALU, shift-add multiply, compare-branch, handshaked
// peripheral write, register file and hardware stack behind a valid/ready handshake.
module alu_exec_unit #(
  parameter int DATA_W      = 16,
  parameter int NREGS       = 16,
  parameter int STACK_DEPTH = 8,
  parameter int REG_AW      = $clog2(NREGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [3:0]        iOpcode,
  input  logic [REG_AW-1:0] iDst,
  input  logic [REG_AW-1:0] iSrc0,
  input  logic [REG_AW-1:0] iSrc1,
  input  logic [DATA_W-1:0] iImm,
  output logic              oBranchValid,
  output logic              oBranchTaken,
  output logic              oPeriphValid,
  input  logic              iPeriphReady,
  output logic [DATA_W-1:0] oPeriphData,
  output logic              oZero,
  output logic              oCarry,
  output logic              oStackErr,
  input  logic [REG_AW-1:0] iDbgAddr,
  output logic [DATA_W-1:0] oDbgData
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_STO  = 4'd4;
  localparam logic [3:0] OP_BLE  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_PUSH = 4'd11;
  localparam logic [3:0] OP_POP  = 4'd12;
  localparam logic [3:0] OP_OUT  = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] rf  [NREGS];
  logic [DATA_W-1:0] stk [STACK_DEPTH];
  logic [SP_W-1:0]   sp, sp_m1;

  logic [2*DATA_W-1:0] acc, mcand, acc_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic [REG_AW-1:0]   mdst;

  logic              accept, mul_done, full, empty;
  logic [DATA_W-1:0] s0, s1, stk_top;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, flag_upd;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign accept   = iValid & oReady;
  assign s0       = rf[iSrc0];
  assign s1       = rf[iSrc1];
  assign oDbgData = rf[iDbgAddr];

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign sp_m1   = sp - 1'b1;
  assign stk_top = stk[sp_m1[SP_W-2:0]];

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == S_MUL) && (cnt == '0);

  // ---------------- FSM ----------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && iOpcode == OP_MUL)      state_nxt = S_MUL;
              else if (accept && iOpcode == OP_OUT) state_nxt = S_OUT;
      S_MUL:  if (cnt == '0)   state_nxt = S_IDLE;
      S_OUT:  if (iPeriphReady) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // oReady is gated by Reset so it only rises once reset is released
  always_comb begin
    oReady       = (state == S_IDLE) & Reset;
    oPeriphValid = (state == S_OUT);
  end

  // ---------------- single-cycle ALU ----------------
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    flag_upd = 1'b1;
    case (iOpcode)
      OP_ADD: {alu_c, alu_res} = {1'b0, s1} + {1'b0, s0};
      OP_SUB: {alu_c, alu_res} = {1'b0, s1} - {1'b0, s0};
      OP_AND: alu_res = s1 & s0;
      OP_OR:  alu_res = s1 | s0;
      OP_XOR: alu_res = s1 ^ s0;
      OP_SHL: begin alu_res = {s1[DATA_W-2:0], 1'b0}; alu_c = s1[DATA_W-1]; end
      OP_SHR: begin alu_res = {1'b0, s1[DATA_W-1:1]}; alu_c = s1[0]; end
      default: flag_upd = 1'b0;
    endcase
  end

  // Register file write port; MUL completion cannot collide with an accept
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = iDst;
    wr_data = alu_res;
    if (mul_done) begin
      wr_en   = 1'b1;
      wr_addr = mdst;
      wr_data = acc_nxt[DATA_W-1:0];
    end else if (accept) begin
      case (iOpcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: wr_en = 1'b1;
        OP_STO: begin wr_en = 1'b1; wr_data = iImm; end
        OP_POP: begin wr_en = 1'b1; wr_data = empty ? '0 : stk_top; end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  // ---------------- flags ----------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oZero  <= 1'b0;
      oCarry <= 1'b0;
    end else if (mul_done) begin
      oZero  <= (acc_nxt[DATA_W-1:0] == '0);
      oCarry <= |acc_nxt[2*DATA_W-1:DATA_W];
    end else if (accept && flag_upd) begin
      oZero  <= (alu_res == '0);
      oCarry <= alu_c;
    end
  end

  // ---------------- multiplier ----------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      mdst   <= '0;
    end else if (accept && iOpcode == OP_MUL) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, s1};
      mplier <= s0;
      cnt    <= CNT_W'(DATA_W - 1);
      mdst   <= iDst;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  // ---------------- branch and peripheral ----------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oBranchValid <= 1'b0;
      oBranchTaken <= 1'b0;
      oPeriphData  <= '0;
    end else begin
      oBranchValid <= accept && (iOpcode == OP_BLE);
      oBranchTaken <= accept && (iOpcode == OP_BLE) && (s1 <= s0);
      if (accept && iOpcode == OP_OUT) oPeriphData <= s1;
    end
  end

  // ---------------- stack ----------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
      sp        <= '0;
      oStackErr <= 1'b0;
    end else if (accept && iOpcode == OP_PUSH) begin
      if (full) oStackErr <= 1'b1;
      else begin
        stk[sp[SP_W-2:0]] <= s0;
        sp <= sp + 1'b1;
      end
    end else if (accept && iOpcode == OP_POP) begin
      if (empty) oStackErr <= 1'b1;
      else       sp <= sp_m1;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: each task drives one scenario and checks inline.
module tb_alu_exec_unit;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, STO = 4'd4,
                         BLE = 4'd5, AND = 4'd6, OR = 4'd7, XOR = 4'd8, SHL = 4'd9,
                         SHR = 4'd10, PUSH = 4'd11, POP = 4'd12, OUT = 4'd13;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [3:0]  iOpcode = 4'd0;
  logic [3:0]  iDst = 4'd0, iSrc0 = 4'd0, iSrc1 = 4'd0;
  logic [15:0] iImm = 16'd0;
  logic        oBranchValid, oBranchTaken, oPeriphValid;
  logic        iPeriphReady = 1'b0;
  logic [15:0] oPeriphData;
  logic        oZero, oCarry, oStackErr;
  logic [3:0]  iDbgAddr = 4'd0;
  logic [15:0] oDbgData;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.DATA_W(16), .NREGS(16), .STACK_DEPTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iOpcode(iOpcode), .iDst(iDst), .iSrc0(iSrc0), .iSrc1(iSrc1), .iImm(iImm),
    .oBranchValid(oBranchValid), .oBranchTaken(oBranchTaken),
    .oPeriphValid(oPeriphValid), .iPeriphReady(iPeriphReady), .oPeriphData(oPeriphData),
    .oZero(oZero), .oCarry(oCarry), .oStackErr(oStackErr),
    .iDbgAddr(iDbgAddr), .oDbgData(oDbgData)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Present one instruction for one edge; returns 1ns after that edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] src1,
                       input logic [3:0] src0, input logic [15:0] imm);
    iValid = 1'b1; iOpcode = op; iDst = dst; iSrc1 = src1; iSrc0 = src0; iImm = imm;
    @(posedge Clock); #1;
    iValid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] v);
    iDbgAddr = a; #1;
    v = oDbgData;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_cmp++; if (oReady !== 1'b0) begin n_err++; $display("FAIL rst_ready_low: got %b want 0", oReady); end
    Reset = 1'b1;
    #1;
    n_cmp++; if (oReady !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", oReady); end
    n_cmp++;
    if ({oZero, oCarry, oStackErr, oPeriphValid, oBranchValid, oBranchTaken} !== 6'b0) begin
      n_err++; $display("FAIL rst_outputs: got %b want 000000",
        {oZero, oCarry, oStackErr, oPeriphValid, oBranchValid, oBranchTaken});
    end
    rd(4'd3, v);
    n_cmp++; if (v !== 16'h0) begin n_err++; $display("FAIL rst_r3: got %h want 0000", v); end
    @(posedge Clock); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    logic        rdy_ok = 1'b1;
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h0007); rdy_ok &= oReady;
    issue(STO, 4'd2, 4'd0, 4'd0, 16'h0005); rdy_ok &= oReady;
    issue(ADD, 4'd3, 4'd1, 4'd2, 16'h0);    rdy_ok &= oReady;
    n_cmp++; if (rdy_ok !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", rdy_ok); end
    rd(4'd3, v);
    n_cmp++; if (v !== 16'h000C) begin n_err++; $display("FAIL add_r3: got %h want 000c", v); end
    n_cmp++; if ({oZero, oCarry} !== 2'b00) begin n_err++; $display("FAIL add_flags: got %b want 00", {oZero, oCarry}); end
  endtask

  task automatic test_carry;
    logic [15:0] v;
    issue(STO, 4'd1, 4'd0, 4'd0, 16'hFFFF);
    issue(STO, 4'd2, 4'd0, 4'd0, 16'h0001);
    issue(ADD, 4'd3, 4'd1, 4'd2, 16'h0);
    rd(4'd3, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL addc_r3: got %h want 0000", v); end
    n_cmp++; if ({oZero, oCarry} !== 2'b11) begin n_err++; $display("FAIL addc_flags: got %b want 11", {oZero, oCarry}); end
    issue(SUB, 4'd4, 4'd2, 4'd1, 16'h0);
    rd(4'd4, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL sub_r4: got %h want 0002", v); end
    n_cmp++; if ({oZero, oCarry} !== 2'b01) begin n_err++; $display("FAIL sub_flags: got %b want 01", {oZero, oCarry}); end
  endtask

  task automatic test_logic;
    logic [15:0] v;
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h8001);
    issue(STO, 4'd2, 4'd0, 4'd0, 16'h00FF);
    issue(SHL, 4'd8, 4'd1, 4'd0, 16'h0);
    rd(4'd8, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL shl_val: got %h want 0002", v); end
    n_cmp++; if ({oZero, oCarry} !== 2'b01) begin n_err++; $display("FAIL shl_flags: got %b want 01", {oZero, oCarry}); end
    issue(AND, 4'd10, 4'd1, 4'd2, 16'h0);
    n_cmp++; if (oCarry !== 1'b0) begin n_err++; $display("FAIL and_carry: got %b want 0", oCarry); end
    issue(SHR, 4'd9, 4'd1, 4'd0, 16'h0);
    rd(4'd9, v);
    n_cmp++; if (v !== 16'h4000) begin n_err++; $display("FAIL shr_val: got %h want 4000", v); end
    n_cmp++; if (oCarry !== 1'b1) begin n_err++; $display("FAIL shr_carry: got %b want 1", oCarry); end
    rd(4'd10, v);
    n_cmp++; if (v !== 16'h0001) begin n_err++; $display("FAIL and_val: got %h want 0001", v); end
    issue(XOR, 4'd11, 4'd1, 4'd2, 16'h0);
    issue(OR,  4'd12, 4'd1, 4'd2, 16'h0);
    rd(4'd11, v);
    n_cmp++; if (v !== 16'h80FE) begin n_err++; $display("FAIL xor_val: got %h want 80fe", v); end
    rd(4'd12, v);
    n_cmp++; if (v !== 16'h80FF) begin n_err++; $display("FAIL or_val: got %h want 80ff", v); end
    // r2 = r2 + r2 uses the old value; then op 14 and STO leave flags alone
    issue(ADD, 4'd2, 4'd2, 4'd2, 16'h0);
    rd(4'd2, v);
    n_cmp++; if (v !== 16'h01FE) begin n_err++; $display("FAIL same_reg: got %h want 01fe", v); end
    issue(SUB, 4'd13, 4'd1, 4'd1, 16'h0);
    issue(4'd14, 4'd13, 4'd0, 4'd0, 16'h0);
    issue(STO, 4'd14, 4'd0, 4'd0, 16'h1234);
    n_cmp++; if ({oZero, oCarry} !== 2'b10) begin n_err++; $display("FAIL flag_hold: got %b want 10", {oZero, oCarry}); end
  endtask

  task automatic test_mul;
    logic [15:0] v;
    int          busy;
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h0012);
    issue(STO, 4'd2, 4'd0, 4'd0, 16'h0034);
    issue(MUL, 4'd5, 4'd1, 4'd2, 16'h0);
    rd(4'd5, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mul_early_write: got %h want 0000", v); end
    busy = 0;
    while (!oReady && busy < 100) begin busy++; @(posedge Clock); #1; end
    n_cmp++; if (busy != 16) begin n_err++; $display("FAIL mul_busy: got %0d want 16", busy); end
    rd(4'd5, v);
    n_cmp++; if (v !== 16'h03A8) begin n_err++; $display("FAIL mul_val: got %h want 03a8", v); end
    n_cmp++; if ({oZero, oCarry} !== 2'b00) begin n_err++; $display("FAIL mul_flags: got %b want 00", {oZero, oCarry}); end
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h1000);
    issue(STO, 4'd2, 4'd0, 4'd0, 16'h0010);
    issue(MUL, 4'd5, 4'd1, 4'd2, 16'h0);
    busy = 0;
    while (!oReady && busy < 100) begin busy++; @(posedge Clock); #1; end
    n_cmp++; if (busy != 16) begin n_err++; $display("FAIL mul2_busy: got %0d want 16", busy); end
    rd(4'd5, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mul2_val: got %h want 0000", v); end
    n_cmp++; if ({oZero, oCarry} !== 2'b11) begin n_err++; $display("FAIL mul2_flags: got %b want 11", {oZero, oCarry}); end
  endtask

  task automatic test_ble;
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h0003);
    issue(STO, 4'd2, 4'd0, 4'd0, 16'h0003);
    n_cmp++; if (oBranchValid !== 1'b0) begin n_err++; $display("FAIL ble_idle: got %b want 0", oBranchValid); end
    issue(BLE, 4'd0, 4'd1, 4'd2, 16'h0);
    n_cmp++; if ({oBranchValid, oBranchTaken} !== 2'b11) begin n_err++; $display("FAIL ble_eq: got %b want 11", {oBranchValid, oBranchTaken}); end
    @(posedge Clock); #1;
    n_cmp++; if ({oBranchValid, oBranchTaken} !== 2'b00) begin n_err++; $display("FAIL ble_pulse: got %b want 00", {oBranchValid, oBranchTaken}); end
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h0004);
    issue(BLE, 4'd0, 4'd1, 4'd2, 16'h0);
    n_cmp++; if ({oBranchValid, oBranchTaken} !== 2'b10) begin n_err++; $display("FAIL ble_gt: got %b want 10", {oBranchValid, oBranchTaken}); end
    @(posedge Clock); #1;
    n_cmp++; if (oBranchValid !== 1'b0) begin n_err++; $display("FAIL ble_pulse2: got %b want 0", oBranchValid); end
  endtask

  task automatic test_out;
    int  vcnt;
    logic ok = 1'b1;
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h00A5);
    iPeriphReady = 1'b0;
    issue(OUT, 4'd0, 4'd1, 4'd0, 16'h0);
    vcnt = 0;
    while (oPeriphValid && vcnt < 50) begin
      if (oPeriphData !== 16'h00A5 || oReady !== 1'b0) ok = 1'b0;
      vcnt++;
      if (vcnt == 6) iPeriphReady = 1'b1;
      @(posedge Clock); #1;
    end
    iPeriphReady = 1'b0;
    n_cmp++; if (vcnt != 6) begin n_err++; $display("FAIL out_valid_len: got %0d want 6", vcnt); end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL out_hold: data/ready unstable, got ok=%b want 1", ok); end
    n_cmp++; if (oReady !== 1'b1) begin n_err++; $display("FAIL out_done_ready: got %b want 1", oReady); end
  endtask

  task automatic test_stack;
    logic [15:0] v;
    for (int i = 1; i <= 9; i++) begin
      issue(STO, 4'd6, 4'd0, 4'd0, 16'(i));
      issue(PUSH, 4'd0, 4'd0, 4'd6, 16'h0);
      if (i == 8) begin
        n_cmp++; if (oStackErr !== 1'b0) begin n_err++; $display("FAIL push8_err: got %b want 0", oStackErr); end
      end
    end
    n_cmp++; if (oStackErr !== 1'b1) begin n_err++; $display("FAIL push9_err: got %b want 1", oStackErr); end
    for (int i = 1; i <= 9; i++) begin
      issue(POP, 4'd7, 4'd0, 4'd0, 16'h0);
      rd(4'd7, v);
      n_cmp++;
      if (v !== 16'(i == 9 ? 0 : 9 - i)) begin
        n_err++; $display("FAIL pop%0d: got %h want %h", i, v, 16'(i == 9 ? 0 : 9 - i));
      end
    end
    n_cmp++; if (oStackErr !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", oStackErr); end
  endtask

  task automatic test_reset_mid_mul;
    logic [15:0] v;
    logic        all_zero = 1'b1;
    issue(STO, 4'd1, 4'd0, 4'd0, 16'h0012);
    issue(STO, 4'd2, 4'd0, 4'd0, 16'h0034);
    issue(MUL, 4'd5, 4'd1, 4'd2, 16'h0);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    n_cmp++; if (oReady !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", oReady); end
    #2;
    Reset = 1'b1;
    repeat (20) @(posedge Clock);
    #1;
    n_cmp++; if (oReady !== 1'b1) begin n_err++; $display("FAIL midrst_ready_after: got %b want 1", oReady); end
    n_cmp++; if ({oStackErr, oZero, oCarry} !== 3'b000) begin n_err++; $display("FAIL midrst_flags: got %b want 000", {oStackErr, oZero, oCarry}); end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      if (v !== 16'h0) all_zero = 1'b0;
    end
    n_cmp++; if (all_zero !== 1'b1) begin n_err++; $display("FAIL midrst_regs: got nonzero register want all 0000"); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_carry;
    test_logic;
    test_mul;
    test_ble;
    test_out;
    test_stack;
    test_reset_mid_mul;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
